router_pkt_fifo: RTL and testbench
==================================

Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware synchronous FIFO for the router output channels, replacing the fixed 16x8 channel FIFO.
- Sits between the router FSM/register write side and a destination port's read side.
- Generalised in width, depth and header length-field position.
- Adds true full/empty using a wrap-bit pointer scheme, an occupancy count, almost_full, explicit read-valid, end-of-packet and framing-error reporting.

Parameters:
DATA_WIDTH, 8, payload byte width.
DEPTH, 16, number of entries; power of two, at least 4.
LEN_LSB, 2, LSB of the payload-length field inside a header word.
LEN_MSB, 7, MSB of the payload-length field; LEN_LSB <= LEN_MSB < DATA_WIDTH.
AFULL_LEVEL, 12, almost_full asserts when count >= AFULL_LEVEL; 1 <= AFULL_LEVEL <= DEPTH.

Ports:
clock  in  1  single clock; all logic is rising-edge.
resetn  in  1  asynchronous active-low reset.
soft_reset  in  1  synchronous flush, active-high.
write_enb  in  1  write request.
header_in  in  1  marks data_in as a packet header word.
data_in  in  DATA_WIDTH  write data.
read_enb  in  1  read request.
data_out  out  DATA_WIDTH  registered read data.
rd_valid  out  1  data_out was loaded by a read on the previous edge.
pkt_done  out  1  data_out holds the last word (parity) of a packet.
pkt_err  out  1  sticky framing error.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
almost_full  out  1  count >= AFULL_LEVEL.
count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH words, each DATA_WIDTH+1 bits wide ({header_in, data_in}).
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits. The MSB is the wrap bit; the index is the low bits. Pointers wrap naturally, DEPTH-1 -> 0.
- Write accept: write_enb && !full. Read accept: read_enb && !empty. Both use the registered flags from the current cycle.
- Simultaneous accepted read and write: both pointers advance; count is unchanged.
- Write while empty: no bypass. The data becomes readable the next cycle.
- Write while full is dropped silently, even if a read is accepted in the same cycle.
- Read while empty is ignored: data_out holds, rd_valid=0.
- count: +1 on write only, -1 on read only, unchanged otherwise. empty, full and almost_full are registered, derived from the next value of count, and valid the same cycle count updates.
- Read latency is 1 cycle. On an accepted read, data_out <= mem[rd_idx][DATA_WIDTH-1:0] at the edge, and rd_valid=1 for exactly that following cycle. With no accepted read, data_out holds its value and rd_valid=0.
- Packet tracking uses a `remaining` counter, (LEN_MSB-LEN_LSB+2) bits wide, reset value 0.
  - Header word read: remaining <= len + 1 (payload bytes plus parity).
  - Non-header word read with remaining > 0: remaining <= remaining - 1.
  - pkt_done=1 in the rd_valid cycle whose read moved remaining from 1 to 0. A header with len=0 produces pkt_done on the parity word, i.e. the second read.
  - Header read while remaining != 0: pkt_err <= 1 (sticky) and remaining is reloaded from the new header.
  - Non-header read with remaining == 0 (orphan data): pkt_err <= 1; word still delivered with rd_valid.
- soft_reset (synchronous) clears pointers, count, remaining, data_out, rd_valid, pkt_done and pkt_err. Flags become empty=1, full=0, almost_full=0.
  - soft_reset has priority over a read or write in the same cycle; the write is lost.
  - Memory contents are not cleared.
- resetn low (asynchronous) forces the same values as soft_reset immediately, regardless of clock. Deassertion is synchronised externally.
- Reset values: data_out=0, rd_valid=0, pkt_done=0, pkt_err=0, empty=1, full=0, almost_full=0, count=0.
- No X or Z is ever driven on any output.

Test Plan:
1. Reset, then write header 8'h08 (len=2) + 2 payload + parity, then read 4 -> data_out 08,p0,p1,par on consecutive cycles; rd_valid high for 4 cycles; pkt_done only on par; count 4->0; empty=1 at end.
2. Write 16 words without reads -> full=1 when count=16; almost_full=1 from count=12; 17th write dropped (count stays 16, contents unchanged). Then 16 reads return the data in order, exercising pointer wrap.
3. At count=5, write and read in the same cycle for 20 cycles -> count stays 5; data order preserved across wrap; empty/full never toggle.
4. Header len=3, read 2 words, then a second header word reaches the read side -> pkt_err=1 and stays high; remaining reloads to 4; pkt_done after 4 more reads.
5. At count=9, pulse soft_reset with write_enb=1 -> next cycle count=0, empty=1, data_out=0, pkt_err=0; the write is not stored.
6. Assert resetn=0 mid-packet, between clock edges -> outputs take reset values before the next edge. Also: read_enb on empty gives rd_valid=0 and data_out held.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for a router output channel.
// Wrap-bit pointers, registered status flags, one-cycle read latency and packet framing checks.
module router_pkt_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int LEN_LSB     = 2,
    parameter int LEN_MSB     = 7,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    soft_reset,
    input  logic                    write_enb,
    input  logic                    header_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    read_enb,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    pkt_done,
    output logic                    pkt_err,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = LEN_MSB - LEN_LSB + 1;
    localparam int RW = LW + 1;

    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr_next;
    logic [PW-1:0]       rd_ptr_next;
    logic [PW-1:0]       count_next;
    logic [RW-1:0]       remaining;
    logic                wr_acc;
    logic                rd_acc;
    logic [DATA_WIDTH:0] rd_word;
    logic                rd_hdr;
    logic [LW-1:0]       rd_len;

    // Accepts use the registered flags; a soft reset swallows both requests.
    assign wr_acc  = write_enb && !full && !soft_reset;
    assign rd_acc  = read_enb && !empty && !soft_reset;
    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign rd_hdr  = rd_word[DATA_WIDTH];
    assign rd_len  = rd_word[LEN_MSB:LEN_LSB];

    always_comb begin
        wr_ptr_next = wr_ptr + PW'(wr_acc);
        rd_ptr_next = rd_ptr + PW'(rd_acc);
        count_next  = wr_ptr_next - rd_ptr_next;
    end

    // Flags are computed from the next occupancy so they line up with count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == PW'(DEPTH));
            almost_full <= (count_next >= PW'(AFULL_LEVEL));
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= {header_in, data_in};
        end
    end

    // remaining counts the words still owed by the current packet, parity included.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out  <= '0;
            rd_valid  <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            remaining <= '0;
        end else if (soft_reset) begin
            data_out  <= '0;
            rd_valid  <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            remaining <= '0;
        end else begin
            rd_valid <= rd_acc;
            pkt_done <= 1'b0;
            if (rd_acc) begin
                data_out <= rd_word[DATA_WIDTH-1:0];
                if (rd_hdr) begin
                    if (remaining != '0) begin
                        pkt_err <= 1'b1;
                    end
                    remaining <= {1'b0, rd_len} + RW'(1);
                end else if (remaining != '0) begin
                    remaining <= remaining - RW'(1);
                    pkt_done  <= (remaining == RW'(1));
                end else begin
                    pkt_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: vector table, directed corner cases
// and random traffic against a queue-based reference model.
module tb_router_pkt_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       header_in;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       pkt_done;
    logic       pkt_err;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model state: the FIFO is a plain queue of {header, data}.
    logic [8:0] mq[$];
    int         m_rem;
    logic       m_err;
    logic       m_done;
    logic       m_valid;
    logic [7:0] m_dout;

    typedef struct {
        logic       sr;
        logic       we;
        logic       hdr;
        logic [7:0] din;
        logic       re;
        logic [7:0] dout;
        logic       valid;
        logic       done;
        logic       err;
        int         cnt;
    } vec_t;

    vec_t tbl[9];

    router_pkt_fifo dut (
        .clock       (clock),
        .resetn      (resetn),
        .soft_reset  (soft_reset),
        .write_enb   (write_enb),
        .header_in   (header_in),
        .data_in     (data_in),
        .read_enb    (read_enb),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .pkt_done    (pkt_done),
        .pkt_err     (pkt_err),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rem   = 0;
        m_err   = 1'b0;
        m_done  = 1'b0;
        m_valid = 1'b0;
        m_dout  = 8'h00;
    endtask

    task automatic model_step(input logic sr, input logic we, input logic hdr,
                              input logic [7:0] din, input logic re);
        logic       rd;
        logic       wr;
        logic [8:0] w;
        if (sr) begin
            model_reset();
            return;
        end
        rd      = re && (mq.size() > 0);
        wr      = we && (mq.size() < 16);
        m_valid = rd;
        m_done  = 1'b0;
        if (rd) begin
            w      = mq.pop_front();
            m_dout = w[7:0];
            if (w[8]) begin
                if (m_rem != 0) m_err = 1'b1;
                m_rem = int'(w[7:2]) + 1;
            end else if (m_rem > 0) begin
                m_rem  = m_rem - 1;
                m_done = (m_rem == 0);
            end else begin
                m_err = 1'b1;
            end
        end
        if (wr) mq.push_back({hdr, din});
    endtask

    task automatic check_output();
        int n;
        n = mq.size();
        check_val("data_out", 32'(data_out), 32'(m_dout));
        check_val("rd_valid", 32'(rd_valid), 32'(m_valid));
        check_val("pkt_done", 32'(pkt_done), 32'(m_done));
        check_val("pkt_err", 32'(pkt_err), 32'(m_err));
        check_val("count", 32'(count), 32'(n));
        check_val("empty", 32'(empty), 32'(n == 0));
        check_val("full", 32'(full), 32'(n == 16));
        check_val("almost_full", 32'(almost_full), 32'(n >= 12));
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, " data_out"}, 32'(data_out), 32'h0);
        check_val({tag, " rd_valid"}, 32'(rd_valid), 32'h0);
        check_val({tag, " pkt_done"}, 32'(pkt_done), 32'h0);
        check_val({tag, " pkt_err"}, 32'(pkt_err), 32'h0);
        check_val({tag, " empty"}, 32'(empty), 32'h1);
        check_val({tag, " full"}, 32'(full), 32'h0);
        check_val({tag, " almost_full"}, 32'(almost_full), 32'h0);
        check_val({tag, " count"}, 32'(count), 32'h0);
    endtask

    task automatic apply_stimulus(input logic sr, input logic we, input logic hdr,
                                  input logic [7:0] din, input logic re);
        soft_reset = sr;
        write_enb  = we;
        header_in  = hdr;
        data_in    = din;
        read_enb   = re;
        @(posedge clock);
        model_step(sr, we, hdr, din, re);
        #1;
        check_output();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic flush();
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic       sr;
        logic       we;
        logic       hdr;
        logic       re;

        tbl[0] = '{1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'hA2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h5C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 3};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 2};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5C, 1'b1, 1'b1, 1'b0, 0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h5C, 1'b0, 1'b0, 1'b0, 0};

        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        header_in  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 1'b0;
        model_reset();
        #12;
        check_reset_values("por");
        resetn = 1'b1;

        $display("[TB] basic packet from vector table");
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(tbl[i].sr, tbl[i].we, tbl[i].hdr, tbl[i].din, tbl[i].re);
            check_val("tbl data_out", 32'(data_out), 32'(tbl[i].dout));
            check_val("tbl rd_valid", 32'(rd_valid), 32'(tbl[i].valid));
            check_val("tbl pkt_done", 32'(pkt_done), 32'(tbl[i].done));
            check_val("tbl pkt_err", 32'(pkt_err), 32'(tbl[i].err));
            check_val("tbl count", 32'(count), 32'(tbl[i].cnt));
            check_val("tbl empty", 32'(empty), 32'(tbl[i].cnt == 0));
        end

        $display("[TB] fill to full, overflow, drain across wrap");
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        check_val("full at 16", 32'(full), 32'h1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'hEE, 1'b0);
        check_val("count after overflow", 32'(count), 32'd16);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'hEF, 1'b1);
        check_val("full write with read dropped", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("last drained word", 32'(data_out), 32'h3F);
        idle(1);

        $display("[TB] steady concurrent read and write at count 5");
        flush();
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'h60 + i), 1'b1);
        check_val("steady count", 32'(count), 32'd5);

        $display("[TB] header arriving mid packet");
        flush();
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'h0C, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'h0C, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'h21 + i), 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("no err before 2nd header", 32'(pkt_err), 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("err on early header", 32'(pkt_err), 32'h1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("no done before 4th", 32'(pkt_done), 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("done after reload", 32'(pkt_done), 32'h1);
        check_val("err sticky", 32'(pkt_err), 32'h1);

        $display("[TB] soft reset with write pending at count 9");
        for (int i = 0; i < 9; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'hAB, 1'b0);
        check_reset_values("soft");
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("soft write lost", 32'(rd_valid), 32'h0);

        $display("[TB] async reset mid packet");
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'h08, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h91, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h92, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        #3;
        resetn = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'hC3, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("empty read holds", 32'(data_out), 32'hC3);
        check_val("empty read invalid", 32'(rd_valid), 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 1200; i++) begin
            sr  = ($urandom_range(0, 99) == 0);
            hdr = ($urandom_range(0, 4) == 0);
            d   = 8'($urandom);
            if (hdr) d[7:5] = 3'b000;
            if ((i / 150) % 2 == 0) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            apply_stimulus(sr, we, hdr, d, re);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
